// File: rtl/execute_stage.sv
// Execute stage: operand-2 select, ALU, branch resolution, wrong-path squash and EX/MEM register.
// Optional build macro FORWARD_EN enables the EX/MEM -> EX bypass for rs1/rs2.
module execute_stage #(
  parameter int XLEN   = 32,
  parameter int SHADOW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      ALU_CONTROL,
  input  logic [1:0]      ALU_SRC2,
  input  logic            BRN_COND,
  input  logic            MEM_WE,
  input  logic            DE_WE,
  input  logic            MEM_REG,
  input  logic [XLEN-1:0] D1,
  input  logic [XLEN-1:0] D2,
  input  logic [24:0]     Imm,
  input  logic [XLEN-1:0] PC_EX,
  input  logic            MEM_STALL,
  output logic            STALL_EX,
  output logic [XLEN-1:0] ALU_RES_M,
  output logic [XLEN-1:0] D2_M,
  output logic [4:0]      RD_M,
  output logic            MEM_WE_M,
  output logic            DE_WE_M,
  output logic            MEM_REG_M,
  output logic            VALID_M,
  output logic            BRN_TAKEN,
  output logic [XLEN-1:0] BRN_TARGET
);

  localparam logic [1:0] SHADOW_CNT = 2'(SHADOW);

  logic [1:0]      kill_cnt;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_b;
  logic [XLEN-1:0] op_a, op_rs2, op_b;
  logic [XLEN-1:0] alu_res;
  logic [2:0]      funct3;
  logic            lt_s, lt_u, eq, cond_true;
  logic            squash;

  assign STALL_EX = MEM_STALL;
  assign funct3   = Imm[7:5];
  assign squash   = (kill_cnt != 2'd0);

  assign imm_i = {{(XLEN-12){Imm[24]}}, Imm[24:13]};
  assign imm_s = {{(XLEN-12){Imm[24]}}, Imm[24:18], Imm[4:0]};
  assign imm_u = {{(XLEN-31){Imm[24]}}, Imm[23:5], 12'b0};
  assign imm_b = {{(XLEN-12){Imm[24]}}, Imm[0], Imm[23:18], Imm[4:1], 1'b0};

`ifdef FORWARD_EN
  logic [4:0] rs1, rs2;
  logic       fwd_src_ok;

  assign rs1        = Imm[12:8];
  assign rs2        = Imm[17:13];
  // Loads are excluded: their data is not in ALU_RES_M yet.
  assign fwd_src_ok = VALID_M & DE_WE_M & ~MEM_REG_M;
  assign op_a       = (fwd_src_ok && RD_M == rs1 && rs1 != 5'd0) ? ALU_RES_M : D1;
  assign op_rs2     = (fwd_src_ok && RD_M == rs2 && rs2 != 5'd0) ? ALU_RES_M : D2;
`else
  assign op_a   = D1;
  assign op_rs2 = D2;
`endif

  always_comb begin
    op_b = op_rs2;
    case (ALU_SRC2)
      2'b00:   op_b = op_rs2;
      2'b01:   op_b = imm_i;
      2'b10:   op_b = imm_s;
      default: op_b = imm_u;
    endcase
  end

  assign lt_s = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_res = '0;
    case (ALU_CONTROL)
      3'b000:  alu_res = op_a + op_b;
      3'b001:  alu_res = op_a - op_b;
      3'b010:  alu_res = op_a & op_b;
      3'b011:  alu_res = op_a | op_b;
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = op_a << op_b[4:0];
      3'b110:  alu_res = op_a >> op_b[4:0];
      default: alu_res = {{(XLEN-1){1'b0}}, lt_s};
    endcase
  end

  // Branch compares always use rs2, independent of the op-2 select.
  assign eq   = (op_a == op_rs2);
  assign lt_u = (op_a < op_rs2);

  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      3'b000:  cond_true = eq;
      3'b001:  cond_true = ~eq;
      3'b100:  cond_true = $signed(op_a) < $signed(op_rs2);
      3'b101:  cond_true = ~($signed(op_a) < $signed(op_rs2));
      3'b110:  cond_true = lt_u;
      3'b111:  cond_true = ~lt_u;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      kill_cnt   <= 2'd0;
      ALU_RES_M  <= '0;
      D2_M       <= '0;
      RD_M       <= '0;
      MEM_WE_M   <= 1'b0;
      DE_WE_M    <= 1'b0;
      MEM_REG_M  <= 1'b0;
      VALID_M    <= 1'b0;
      BRN_TAKEN  <= 1'b0;
      BRN_TARGET <= '0;
    end else if (MEM_STALL) begin
      BRN_TAKEN <= 1'b0;
    end else begin
      ALU_RES_M <= alu_res;
      D2_M      <= op_rs2;
      RD_M      <= Imm[4:0];
      MEM_REG_M <= MEM_REG;
      MEM_WE_M  <= MEM_WE & ~squash;
      DE_WE_M   <= DE_WE & ~squash;
      VALID_M   <= ~squash;
      if (squash) begin
        kill_cnt  <= kill_cnt - 2'd1;
        BRN_TAKEN <= 1'b0;
      end else if (BRN_COND && cond_true) begin
        kill_cnt   <= SHADOW_CNT;
        BRN_TAKEN  <= 1'b1;
        BRN_TARGET <= PC_EX + imm_b;
      end else begin
        BRN_TAKEN <= 1'b0;
      end
    end
  end

endmodule
